sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ASIZE, default 3, address width; DEPTH = 2**ASIZE words (default 8).
REQ-003 SHALL use one clock and a synchronous, active-low reset; reads and writes both occur on that clock.
REQ-004 wclk  input  1  clock; all state updates on rising edge.
REQ-005 wrst_n  input  1  synchronous active-low reset.
REQ-006 winc  input  1  write request; word accepted on a rising edge when winc=1 and wfull=0.
REQ-007 wdata  input  DSIZE  write data, sampled on the accepting edge.
REQ-008 rinc  input  1  read request; word popped on a rising edge when rinc=1 and rempty=0.
REQ-009 rdata  output  DSIZE  head-of-FIFO word, combinational from memory at the read address (first-word fall-through).
REQ-010 wfull  output  1  registered; 1 when DEPTH words are stored.
REQ-011 rempty  output  1  registered; 1 when 0 words are stored.

Function
REQ-012 SHALL store words in a DEPTH x DSIZE register array; the array is not reset.
REQ-013 SHALL keep write and read pointers of ASIZE+1 bits; the low ASIZE bits address memory, the MSB is a wrap bit.
REQ-014 Pointers SHALL increment modulo 2**(ASIZE+1) and wrap from DEPTH-1 to 0 in address without any dead cycle.
REQ-015 Empty SHALL be detected when pointers are fully equal; full SHALL be detected when the MSBs differ and the low ASIZE bits are equal.
REQ-016 wfull and rempty SHALL be computed from next-state pointers and registered, so a flag reflects the edge that changed occupancy in the same cycle.
REQ-017 Write latency: a word written on edge N SHALL appear on rdata, with rempty=0, after edge N when the FIFO was empty.
REQ-018 Read: on a popping edge the read pointer advances and rdata SHALL show the next word after that edge.
REQ-019 winc while wfull=1 SHALL be ignored: no memory or pointer change, and no data corruption.
REQ-020 rinc while rempty=1 SHALL be ignored: no pointer change.
REQ-021 Simultaneous winc and rinc, neither flag set: both occur; occupancy and flags are unchanged.
REQ-022 Simultaneous winc and rinc with wfull=1: the read occurs, the write is dropped, and wfull falls to 0 after the edge.
REQ-023 Simultaneous winc and rinc with rempty=1: the write occurs, the read is dropped, and rempty falls to 0 after the edge.
REQ-024 The rdata value while rempty=1 is unspecified and SHALL NOT be relied upon.
REQ-025 Ordering SHALL be strictly first-in first-out.

Reset
REQ-026 On a rising edge with wrst_n=0, both pointers SHALL be 0, rempty=1, wfull=0, and the optional flags SHALL be 0; winc and rinc are ignored on that edge.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; the FIFO is empty on the next cycle.

Configuration
REQ-028 With macro FIFO_ERR_FLAGS_EN defined, the module SHALL add the outputs overflow (1 bit) and underflow (1 bit).
REQ-029 overflow is set sticky on an edge with winc=1 and wfull=1; underflow is set sticky on an edge with rinc=1 and rempty=1.
REQ-030 Both flags SHALL be cleared only by reset.
REQ-031 Without FIFO_ERR_FLAGS_EN, these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset: hold wrst_n=0 for 4 edges -> rempty=1, wfull=0; release with rinc=1 and winc=0 -> rempty stays 1 and underflow=1 (if enabled).
REQ-033 Streaming: rinc held at 1, write 10 random words one every 2 cycles -> each word appears on rdata in order, and rempty toggles back to 1 after each pop.
REQ-034 Fill: rinc=0, winc=1 for 11 cycles with data 0x10..0x1A -> wfull=1 after the 8th write, words 0x18..0x1A are dropped, and overflow=1 (if enabled).
REQ-035 Drain: winc=0, rinc=1 for 11 cycles -> rdata = 0x10..0x17 in order, rempty=1 after the 8th pop, and further reads are ignored.
REQ-036 Boundary: at full, assert winc and rinc together -> one pop occurs, wfull=0, and the count becomes 7; at empty, assert both -> one word is stored and rempty=0.
REQ-037 Wrap and reset: perform 20 interleaved writes and reads across pointer wrap with order preserved, then assert reset with 3 words stored -> rempty=1 on the next cycle.

Source files
------------

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word fall-through FIFO
//
// Parameters: DSIZE data width, ASIZE address width (DEPTH = 2**ASIZE words).
// Ports:
//   wclk      clock, all state updates on the rising edge
//   wrst_n    synchronous active-low reset
//   winc      write request, accepted when wfull=0
//   wdata     write data
//   rinc      read request, pops when rempty=0
//   rdata     head-of-FIFO word (combinational read of memory)
//   wfull     registered full flag
//   rempty    registered empty flag
//   overflow  sticky write-while-full flag   (only with FIFO_ERR_FLAGS_EN)
//   underflow sticky read-while-empty flag   (only with FIFO_ERR_FLAGS_EN)
// Optional feature macro: FIFO_ERR_FLAGS_EN

module sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
`ifdef FIFO_ERR_FLAGS_EN
    output logic             rempty,
    output logic             overflow,
    output logic             underflow
`else
    output logic             rempty
`endif
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [0:DEPTH-1];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits match.
    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic [ASIZE:0] wptr_next;
    logic [ASIZE:0] rptr_next;
    logic           do_write;
    logic           do_read;
    logic           wfull_next;
    logic           rempty_next;

    // Flags are registered, so qualifying with the current flags blocks
    // writes at full and reads at empty on the same edge.
    assign do_write = winc & ~wfull;
    assign do_read  = rinc & ~rempty;

    assign wptr_next = wptr + {{ASIZE{1'b0}}, do_write};
    assign rptr_next = rptr + {{ASIZE{1'b0}}, do_read};

    // Flags come from next-state pointers so they track the edge that
    // changed occupancy rather than lagging by a cycle.
    assign rempty_next = (wptr_next == rptr_next);
    assign wfull_next  = (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                         (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            wfull  <= 1'b0;
            rempty <= 1'b1;
        end else begin
            wptr   <= wptr_next;
            rptr   <= rptr_next;
            wfull  <= wfull_next;
            rempty <= rempty_next;
        end
    end

    // Storage is not reset; a write presented during reset is dropped.
    always_ff @(posedge wclk) begin
        if (wrst_n && do_write) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rptr[ASIZE-1:0]];

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo

module tb_sync_fifo;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    sync_fifo #(.DSIZE(8), .ASIZE(3)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .wdata     (wdata),
        .rinc      (rinc),
        .rdata     (rdata),
        .wfull     (wfull),
`ifdef FIFO_ERR_FLAGS_EN
        .rempty    (rempty),
        .overflow  (overflow),
        .underflow (underflow)
`else
        .rempty    (rempty)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int total  = 0;
    int passed = 0;

    // Reference model: a plain queue holding the stored words.
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    typedef struct {
        bit         rst_n;
        bit         winc;
        logic [7:0] wdata;
        bit         rinc;
        bit         e_empty;
        bit         e_full;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_check();
        chk("mdl_rempty", 32'(rempty), 32'(q.size() == 0));
        chk("mdl_wfull", 32'(wfull), 32'(q.size() == 8));
        if (q.size() != 0) chk("mdl_rdata", 32'(rdata), 32'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
        chk("mdl_overflow", 32'(overflow), 32'(m_ovf));
        chk("mdl_underflow", 32'(underflow), 32'(m_unf));
`endif
    endtask

    // Drive one cycle, advance the model by the same edge, compare.
    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rd);
        int sz;
        wrst_n = r;
        winc   = w;
        wdata  = d;
        rinc   = rd;
        @(posedge wclk);
        #1;
        sz = q.size();
        if (!r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && sz == 8) m_ovf = 1'b1;
            if (rd && sz == 0) m_unf = 1'b1;
            if (rd && sz > 0) void'(q.pop_front());
            if (w && sz < 8) q.push_back(d);
        end
        model_check();
    endtask

    initial begin
        int idx;
        int pw;
        int pr;
        logic [7:0] d;

        wrst_n = 1'b0;
        winc   = 1'b0;
        wdata  = 8'h00;
        rinc   = 1'b0;

        // Vector table: reset (requests ignored during reset), release with
        // a read at empty, fill 11 words, drain 11 pops, both at empty.
        idx = 0;
        for (int i = 0; i < 4; i++) tbl[idx++] = '{1'b0, i == 3, 8'hAA, i == 3, 1'b1, 1'b0, 8'h00};
        tbl[idx++] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        for (int k = 1; k <= 11; k++)
            tbl[idx++] = '{1'b1, 1'b1, 8'(8'h0F + k), 1'b0, 1'b0, k >= 8, 8'h10};
        for (int k = 1; k <= 11; k++)
            tbl[idx++] = '{1'b1, 1'b0, 8'h00, 1'b1, k >= 8, 1'b0, (k < 8) ? 8'(8'h10 + k) : 8'h00};
        tbl[idx++] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55};

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].rst_n, tbl[i].winc, tbl[i].wdata, tbl[i].rinc);
            chk($sformatf("tbl%0d_rempty", i), 32'(rempty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_wfull", i), 32'(wfull), 32'(tbl[i].e_full));
            if (!tbl[i].e_empty) chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].e_data));
`ifdef FIFO_ERR_FLAGS_EN
            if (i == 4) chk("tbl_underflow", 32'(underflow), 32'd1);
            if (i == 15) chk("tbl_overflow", 32'(overflow), 32'd1);
`endif
        end

        // Boundary at full: fill to 8 behind 0x55, then push and pop together.
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 8'(8'h60 + k), 1'b0);
        chk("bnd_full_before", 32'(wfull), 32'd1);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("bnd_full_after", 32'(wfull), 32'd0);
        chk("bnd_head_after", 32'(rdata), 32'h60);
        chk("bnd_count", 32'(q.size()), 32'd7);

        // Streaming with rinc held: each word shows up, then pops to empty.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            step(1'b1, 1'b1, d, 1'b1);
            chk("strm_data", 32'(rdata), 32'(d));
            chk("strm_nonempty", 32'(rempty), 32'd0);
            step(1'b1, 1'b0, 8'h00, 1'b1);
            chk("strm_empty", 32'(rempty), 32'd1);
        end

        // Wrap: hold 3 words while pushing and popping across pointer wrap.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'(8'hA0 + k), 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 8'(8'hC0 + k), 1'b1);
        chk("wrap_head", 32'(rdata), 32'hD1);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        chk("rst_mid_empty", 32'(rempty), 32'd1);
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        chk("post_rst_data", 32'(rdata), 32'h3C);

        // Randomized run with phases biased toward full or empty.
        pw = 50;
        pr = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 80 == 0) begin
                pw = 20 + 30 * $urandom_range(2);
                pr = 20 + 30 * $urandom_range(2);
            end
            step($urandom_range(199) != 0, $urandom_range(99) < pw, 8'($urandom),
                 $urandom_range(99) < pr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
